// File: rtl/mont_sched.sv
// mont_sched: issue scheduler in front of a pipelined Montgomery multiplier.
//
// Two requesters present operands; a round-robin arbiter grants at most one per cycle and the
// granted operand goes straight to the datapath (mont_start_o/mont_x_o, same cycle). The
// requester ID of every issued operation is pushed into a small in-order tag FIFO. When the
// datapath returns a result (mont_valid_i), the oldest tag is popped and the result is
// registered onto that requester's response port for one cycle.
//
// The modulus, its inverse and the modulus bit length ceil(log2(m)) are held in registers and
// may only be rewritten while nothing is in flight.
//
// Build option: define MONT_SCHED_FIXED_PRIO_EN to replace round-robin with fixed priority
// (requester 0 always wins a tie). Default build (undefined) is round-robin.
//
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   req{0,1}_valid_i/_x_i/_ready_o  requester operand handshake
//   cfg_we_i, cfg_m_i, cfg_minv_i   modulus / inverse write
//   mont_start_o, mont_x_o          issue to datapath
//   mont_m_o, mont_minv_o, mont_m_bl_o  held configuration to datapath
//   mont_result_i, mont_valid_i     datapath result return
//   rsp{0,1}_valid_o/_data_o        per-requester result
//   busy_o                          operations in flight
//   cfg_err_o                       one-cycle pulse: config write refused while busy
//   tag_err_o                       sticky: result returned with nothing in flight
module mont_sched #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,

  input  logic             req0_valid_i,
  input  logic [WIDTH-1:0] req0_x_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [WIDTH-1:0] req1_x_i,
  output logic             req1_ready_o,

  input  logic             cfg_we_i,
  input  logic [WIDTH-1:0] cfg_m_i,
  input  logic [WIDTH-1:0] cfg_minv_i,

  output logic             mont_start_o,
  output logic [WIDTH-1:0] mont_x_o,
  output logic [WIDTH-1:0] mont_m_o,
  output logic [WIDTH-1:0] mont_minv_o,
  output logic [WIDTH-1:0] mont_m_bl_o,
  input  logic [WIDTH-1:0] mont_result_i,
  input  logic             mont_valid_i,

  output logic             rsp0_valid_o,
  output logic [WIDTH-1:0] rsp0_data_o,
  output logic             rsp1_valid_o,
  output logic [WIDTH-1:0] rsp1_data_o,

  output logic             busy_o,
  output logic             cfg_err_o,
  output logic             tag_err_o
);

  localparam int unsigned PtrW = $clog2(TAG_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // ceil(log2(v)) equals the bit length of (v - 1); v = 0 and v = 1 both give 0.
  function automatic logic [WIDTH-1:0] ceil_log2(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] r;
    r = '0;
    t = v - WIDTH'(1);
    if (v > WIDTH'(1)) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (t[i]) r = WIDTH'(i + 1);
      end
    end
    return r;
  endfunction

  // Tag FIFO: one bit per slot holding the requester ID.
  logic [TAG_DEPTH-1:0] tag_q;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]     m_q, minv_q, m_bl_q;
  logic                 cfg_err_q, tag_err_q;
  logic                 rsp0_valid_q, rsp1_valid_q;
  logic [WIDTH-1:0]     rsp0_data_q, rsp1_data_q;

  logic busy, full, pop, push, pop_id, cfg_wr, issue_ok;
  logic gnt0, gnt1;

  always_comb begin
    busy   = (cnt_q != '0);
    full   = (cnt_q == CntW'(TAG_DEPTH));
    pop    = mont_valid_i && busy;
    pop_id = tag_q[rd_ptr_q];
    // An accepted config write takes the cycle; requests wait.
    cfg_wr = cfg_we_i && !busy;
    // A pop in the same cycle frees a slot, so a full FIFO may still accept one issue.
    issue_ok = (m_q != '0) && (!full || pop) && !cfg_wr;
  end

`ifndef MONT_SCHED_FIXED_PRIO_EN
  // prio_q = 1: requester 1 wins a tie.
  logic prio_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= 1'b0;
    end else if (push) begin
      prio_q <= gnt0;
    end
  end
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (issue_ok) begin
`ifdef MONT_SCHED_FIXED_PRIO_EN
      gnt0 = req0_valid_i;
      gnt1 = req1_valid_i && !req0_valid_i;
`else
      if (req0_valid_i && req1_valid_i) begin
        gnt0 = !prio_q;
        gnt1 = prio_q;
      end else begin
        gnt0 = req0_valid_i;
        gnt1 = req1_valid_i;
      end
`endif
    end
    push = gnt0 || gnt1;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      m_q          <= '0;
      minv_q       <= '0;
      m_bl_q       <= '0;
      cfg_err_q    <= 1'b0;
      tag_err_q    <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= gnt1;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      cnt_q <= cnt_d;

      rsp0_valid_q <= pop && !pop_id;
      rsp1_valid_q <= pop && pop_id;
      if (pop && !pop_id) rsp0_data_q <= mont_result_i;
      if (pop && pop_id)  rsp1_data_q <= mont_result_i;

      if (cfg_wr) begin
        m_q    <= cfg_m_i;
        minv_q <= cfg_minv_i;
        m_bl_q <= ceil_log2(cfg_m_i);
      end
      cfg_err_q <= cfg_we_i && busy;

      // Result with nothing in flight is dropped and flagged until reset.
      if (mont_valid_i && !busy) tag_err_q <= 1'b1;
    end
  end

  always_comb begin
    req0_ready_o = gnt0;
    req1_ready_o = gnt1;
    mont_start_o = push;
    mont_x_o     = gnt1 ? req1_x_i : (gnt0 ? req0_x_i : '0);
    mont_m_o     = m_q;
    mont_minv_o  = minv_q;
    mont_m_bl_o  = m_bl_q;
    rsp0_valid_o = rsp0_valid_q;
    rsp0_data_o  = rsp0_data_q;
    rsp1_valid_o = rsp1_valid_q;
    rsp1_data_o  = rsp1_data_q;
    busy_o       = busy;
    cfg_err_o    = cfg_err_q;
    tag_err_o    = tag_err_q;
  end

endmodule

// File: tb/tb_mont_sched.sv
// Randomized bench for mont_sched with a queue-based reference model and a stub datapath
// returning (x ^ KEY) after LAT cycles, optionally stalled.
module tb_mont_sched;

  localparam int unsigned W   = 64;
  localparam int unsigned D   = 8;
  localparam int          LAT = 3;
  localparam logic [W-1:0] KEY   = 64'h5DEE_CE66_D123_4567;
  localparam logic [W-1:0] M_REF = 64'h3A32_E4C4_C7A8_C21B;
  localparam logic [W-1:0] I_REF = 64'hD988_C5E7_CA39_B7ED;
`ifdef MONT_SCHED_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic         clk_i, rst_ni;
  logic         req0_valid_i, req1_valid_i, req0_ready_o, req1_ready_o;
  logic [W-1:0] req0_x_i, req1_x_i;
  logic         cfg_we_i;
  logic [W-1:0] cfg_m_i, cfg_minv_i;
  logic         mont_start_o, mont_valid_i;
  logic [W-1:0] mont_x_o, mont_m_o, mont_minv_o, mont_m_bl_o, mont_result_i;
  logic         rsp0_valid_o, rsp1_valid_o;
  logic [W-1:0] rsp0_data_o, rsp1_data_o;
  logic         busy_o, cfg_err_o, tag_err_o;

  mont_sched #(.WIDTH(W), .TAG_DEPTH(D)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req0_valid_i (req0_valid_i),
    .req0_x_i     (req0_x_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_x_i     (req1_x_i),
    .req1_ready_o (req1_ready_o),
    .cfg_we_i     (cfg_we_i),
    .cfg_m_i      (cfg_m_i),
    .cfg_minv_i   (cfg_minv_i),
    .mont_start_o (mont_start_o),
    .mont_x_o     (mont_x_o),
    .mont_m_o     (mont_m_o),
    .mont_minv_o  (mont_minv_o),
    .mont_m_bl_o  (mont_m_bl_o),
    .mont_result_i(mont_result_i),
    .mont_valid_i (mont_valid_i),
    .rsp0_valid_o (rsp0_valid_o),
    .rsp0_data_o  (rsp0_data_o),
    .rsp1_valid_o (rsp1_valid_o),
    .rsp1_data_o  (rsp1_data_o),
    .busy_o       (busy_o),
    .cfg_err_o    (cfg_err_o),
    .tag_err_o    (tag_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [W-1:0] md_m, md_minv, md_bl;
  int           md_tags[$];
  int           md_prio;
  bit           md_tag_err, md_cfg_err;
  int           md_rsp_id;
  logic [W-1:0] md_rsp_d;

  // Datapath stub state
  logic [W-1:0] dp_data[$];
  int           dp_due[$];
  bit           dp_hold, dp_release, dp_spurious;

  int cyc;
  int gnt_log[$];
  bit last_r0, last_r1, last_cfg_err;

  // Smallest k with 2**k >= m.
  function automatic logic [W-1:0] ref_bl(input logic [W-1:0] m);
    logic [W:0] p;
    int k;
    p = 1;
    k = 0;
    while (p < {1'b0, m}) begin
      p = p << 1;
      k++;
    end
    return W'(k);
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic model_reset(input bit keep_dp);
    md_m = '0; md_minv = '0; md_bl = '0;
    md_tags.delete();
    md_prio = 0; md_tag_err = 0; md_cfg_err = 0; md_rsp_id = -1; md_rsp_d = '0;
    if (!keep_dp) begin
      dp_data.delete();
      dp_due.delete();
    end
  endtask

  task automatic tick();
    bit consumed, pop, full, cfgw, can;
    int win, sz, id;
    logic [W-1:0] rdat;
    consumed = 0;
    mont_valid_i  = 1'b0;
    mont_result_i = '0;
    if (dp_spurious) begin
      mont_valid_i  = 1'b1;
      mont_result_i = 64'h0BAD_0BAD_0BAD_0BAD;
      dp_spurious   = 0;
    end else if (dp_data.size() > 0 && dp_due[0] <= cyc &&
                 (dp_hold ? dp_release : ($urandom_range(3) != 0))) begin
      mont_valid_i  = 1'b1;
      mont_result_i = dp_data[0];
      consumed      = 1;
    end
    dp_release = 0;
    @(negedge clk_i);

    sz   = md_tags.size();
    pop  = mont_valid_i && sz > 0;
    full = (sz == D);
    cfgw = cfg_we_i && sz == 0;
    can  = (md_m != '0) && (!full || pop) && !cfgw;
    win  = -1;
    if (can) begin
      if (req0_valid_i && req1_valid_i) win = FIXED ? 0 : md_prio;
      else if (req0_valid_i) win = 0;
      else if (req1_valid_i) win = 1;
    end

    last_r0 = req0_ready_o;
    last_r1 = req1_ready_o;
    last_cfg_err = cfg_err_o;
    if (req1_ready_o) gnt_log.push_back(1);
    else if (req0_ready_o) gnt_log.push_back(0);

    check_eq("ready0", W'(req0_ready_o), W'(win == 0));
    check_eq("ready1", W'(req1_ready_o), W'(win == 1));
    check_eq("start", W'(mont_start_o), W'(win >= 0));
    if (win >= 0) check_eq("mont_x", mont_x_o, (win == 1) ? req1_x_i : req0_x_i);
    check_eq("rsp0_valid", W'(rsp0_valid_o), W'(md_rsp_id == 0));
    check_eq("rsp1_valid", W'(rsp1_valid_o), W'(md_rsp_id == 1));
    if (md_rsp_id == 0) check_eq("rsp0_data", rsp0_data_o, md_rsp_d);
    if (md_rsp_id == 1) check_eq("rsp1_data", rsp1_data_o, md_rsp_d);
    check_eq("busy", W'(busy_o), W'(sz != 0));
    check_eq("cfg_err", W'(cfg_err_o), W'(md_cfg_err));
    check_eq("tag_err", W'(tag_err_o), W'(md_tag_err));
    check_eq("mont_m", mont_m_o, md_m);
    check_eq("mont_minv", mont_minv_o, md_minv);
    check_eq("mont_m_bl", mont_m_bl_o, md_bl);

    // Advance the model by one clock.
    md_rsp_id = -1;
    if (pop) begin
      id = md_tags.pop_front();
      md_rsp_id = id;
      md_rsp_d  = mont_result_i;
    end
    if (mont_valid_i && !pop) md_tag_err = 1;
    if (win >= 0) begin
      md_tags.push_back(win);
      md_prio = 1 - win;
      rdat = ((win == 1) ? req1_x_i : req0_x_i) ^ KEY;
      dp_data.push_back(rdat);
      dp_due.push_back(cyc + LAT);
    end
    md_cfg_err = cfg_we_i && sz != 0;
    if (cfgw) begin
      md_m = cfg_m_i; md_minv = cfg_minv_i; md_bl = ref_bl(cfg_m_i);
    end
    if (consumed) begin
      void'(dp_data.pop_front());
      void'(dp_due.pop_front());
    end

    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input bit keep_dp);
    rst_ni = 1'b0;
    mont_valid_i = 1'b0;
    #1;
    check_eq("rst_ready0", W'(req0_ready_o), '0);
    check_eq("rst_ready1", W'(req1_ready_o), '0);
    check_eq("rst_start", W'(mont_start_o), '0);
    check_eq("rst_x", mont_x_o, '0);
    check_eq("rst_rsp0", {rsp0_data_o[W-2:0], rsp0_valid_o}, '0);
    check_eq("rst_rsp1", {rsp1_data_o[W-2:0], rsp1_valid_o}, '0);
    check_eq("rst_busy", W'(busy_o), '0);
    check_eq("rst_errs", W'({cfg_err_o, tag_err_o}), '0);
    check_eq("rst_cfg", mont_m_o | mont_minv_o | mont_m_bl_o, '0);
    model_reset(keep_dp);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cyc++;
  endtask

  task automatic idle_inputs();
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; cfg_we_i = 1'b0;
  endtask

  task automatic drain();
    bit save;
    save = dp_hold;
    dp_hold = 0;
    idle_inputs();
    for (int i = 0; i < 300 && (md_tags.size() != 0 || dp_data.size() != 0); i++) tick();
    tick();
    check_eq("drain_busy", W'(busy_o), '0);
    dp_hold = save;
  endtask

  task automatic write_cfg(input logic [W-1:0] m, input logic [W-1:0] minv);
    cfg_we_i = 1'b1; cfg_m_i = m; cfg_minv_i = minv;
    tick();
    cfg_we_i = 1'b0;
  endtask

  initial begin
    int grants;
    logic [W-1:0] m2;
    cyc = 0;
    dp_hold = 0; dp_release = 0; dp_spurious = 0;
    idle_inputs();
    req0_x_i = '0; req1_x_i = '0; cfg_m_i = '0; cfg_minv_i = '0;
    mont_valid_i = 1'b0; mont_result_i = '0;
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    do_reset(0);

    // Reference modulus and bit length
    write_cfg(M_REF, I_REF);
    tick();
    check_eq("m_bl_62", mont_m_bl_o, 64'd62);
    check_eq("m_ref", mont_m_o, M_REF);
    check_eq("minv_ref", mont_minv_o, I_REF);

    // Both requesters valid for six cycles
    gnt_log.delete();
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req0_x_i = rnd64(); req1_x_i = rnd64();
      tick();
    end
    idle_inputs();
    check_eq("rr_count", W'(gnt_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++)
      check_eq($sformatf("rr_seq%0d", i), W'(gnt_log[i]), FIXED ? '0 : W'(i % 2));
    drain();

    // Random traffic with random datapath gaps and occasional config writes
    for (int i = 0; i < 400; i++) begin
      req0_valid_i = ($urandom_range(9) < 7);
      req1_valid_i = ($urandom_range(9) < 7);
      req0_x_i = rnd64(); req1_x_i = rnd64();
      cfg_we_i = ($urandom_range(39) == 0);
      case ($urandom_range(7))
        0:       cfg_m_i = '0;
        1:       cfg_m_i = 64'd1;
        2:       cfg_m_i = 64'd2;
        3:       cfg_m_i = 64'h8000_0000_0000_0001;
        4:       cfg_m_i = 64'h0000_0001_0000_0000;
        default: cfg_m_i = rnd64();
      endcase
      cfg_minv_i = rnd64();
      tick();
    end
    drain();
    write_cfg(M_REF, I_REF);

    // FIFO full with datapath stalled, then one return frees a slot in the same cycle
    dp_hold = 1;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    gnt_log.delete();
    for (int i = 0; i < 8; i++) begin
      req0_x_i = rnd64(); req1_x_i = rnd64();
      tick();
    end
    check_eq("fill_grants", W'(gnt_log.size()), 64'd8);
    tick();
    check_eq("full_block", W'(last_r0 | last_r1), '0);
    dp_release = 1;
    tick();
    check_eq("pop_grant", W'(last_r0 | last_r1), 64'd1);
    drain();

    // Config write refused while busy, accepted after drain
    dp_hold = 1;
    req0_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_x_i = rnd64();
      tick();
    end
    idle_inputs();
    m2 = 64'h0000_00F0_0000_0011;
    write_cfg(m2, 64'h1234);
    tick();
    check_eq("cfg_err_pulse", W'(last_cfg_err), 64'd1);
    check_eq("m_keep", mont_m_o, M_REF);
    tick();
    check_eq("cfg_err_once", W'(cfg_err_o), '0);
    drain();
    write_cfg(m2, 64'h1234);
    check_eq("m_new", mont_m_o, m2);
    check_eq("m_bl_new", mont_m_bl_o, 64'd40);

    // Result with nothing in flight
    dp_spurious = 1;
    tick();
    tick();
    check_eq("tag_err_set", W'(tag_err_o), 64'd1);
    for (int i = 0; i < 3; i++) tick();
    check_eq("tag_err_sticky", W'(tag_err_o), 64'd1);

    // Reset with four in flight; stale results return afterwards
    dp_hold = 1;
    req1_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req1_x_i = rnd64();
      tick();
    end
    idle_inputs();
    do_reset(1);
    dp_hold = 0;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    gnt_log.delete();
    for (int i = 0; i < 12; i++) tick();
    check_eq("no_issue_unconfigured", W'(gnt_log.size()), '0);
    check_eq("stale_tag_err", W'(tag_err_o), 64'd1);
    write_cfg(M_REF, I_REF);
    grants = 0;
    for (int i = 0; i < 4; i++) begin
      req0_x_i = rnd64(); req1_x_i = rnd64();
      tick();
      grants += int'(last_r0 | last_r1);
    end
    check_eq("resume_grants", W'(grants), 64'd4);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
